// File: rtl/array_heap_arbiter.sv
// array_heap_arbiter
//   Shared array-heap manager for generated programs. Owns the element heap,
//   the per-array size table and the stack of freed array ids. Two requesters
//   issue array commands; they are arbitrated round-robin and executed one at
//   a time through an IDLE -> EXEC -> RESP sequence. Each array owns a fixed
//   area of NArea elements starting at heap address array*NArea.
//
// Ports
//   clock       single clock, all state changes on posedge
//   reset       synchronous, active-high; abandons any command in flight
//   req_valid   [1:0] per-requester command valid
//   req_ready   [1:0] per-requester accept, combinational, IDLE only, one-hot
//   req_op      [5:0] op per requester, bits [3r+2:3r]
//               0 ALLOC 1 FREE 2 PUSH 3 POP 4 SIZE 5 READ 6 WRITE 7 reserved
//   req_array   array id per requester
//   req_index   element index per requester (READ/WRITE)
//   req_data    write/push data per requester
//   resp_valid  one-cycle pulse in RESP
//   resp_id     requester the response belongs to (held outside RESP)
//   resp_data   result word (held outside RESP)
//   resp_error  command rejected, no state changed (held outside RESP)
//   busy        FSM not IDLE
module array_heap_arbiter #(
   parameter int MemoryElementWidth = 12,
   parameter int NArrays            = 8,
   parameter int NArea              = 4
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [1:0]                      req_valid,
   output logic [1:0]                      req_ready,
   input  logic [5:0]                      req_op,
   input  logic [2*MemoryElementWidth-1:0] req_array,
   input  logic [2*MemoryElementWidth-1:0] req_index,
   input  logic [2*MemoryElementWidth-1:0] req_data,
   output logic                            resp_valid,
   output logic                            resp_id,
   output logic [MemoryElementWidth-1:0]   resp_data,
   output logic                            resp_error,
   output logic                            busy
);

   localparam int W  = MemoryElementWidth;
   localparam int HD = NArrays * NArea;
   localparam int AW = (HD > 1) ? $clog2(HD) : 1;
   localparam int IW = (NArrays > 1) ? $clog2(NArrays) : 1;
   localparam int CW = $clog2(NArrays + 1);

   localparam logic [2:0] OP_ALLOC = 3'd0;
   localparam logic [2:0] OP_FREE  = 3'd1;
   localparam logic [2:0] OP_PUSH  = 3'd2;
   localparam logic [2:0] OP_POP   = 3'd3;
   localparam logic [2:0] OP_SIZE  = 3'd4;
   localparam logic [2:0] OP_READ  = 3'd5;
   localparam logic [2:0] OP_WRITE = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t         state, state_nxt;
   logic           rr;
   logic           grant;
   logic           accept;

   // command latched at the handshake, consumed in EXEC
   logic [2:0]     op_p1;
   logic [W-1:0]   arr_p1;
   logic [W-1:0]   idx_p1;
   logic [W-1:0]   dat_p1;
   logic           id_p1;

   logic [CW-1:0]  allocs;
   logic [CW-1:0]  top;
   logic [IW-1:0]  stack [NArrays];
   logic [W-1:0]   sizes [NArrays];
   logic [W-1:0]   heap  [HD];

   // EXEC decode results
   logic           ex_err;
   logic [W-1:0]   ex_data;
   logic           heap_we;
   logic [AW-1:0]  heap_wa;
   logic           size_we;
   logic [IW-1:0]  size_wa;
   logic [W-1:0]   size_wd;
   logic           alloc_inc;
   logic           stk_push;
   logic           stk_pop;
   logic [IW-1:0]  aidx;
   logic [W-1:0]   cur_size;
   logic [31:0]    arr_ext;
   logic [31:0]    idx_ext;
   logic [31:0]    cur_ext;
   logic [31:0]    base;

   // Arbitration: the round-robin favourite wins if it is asking, otherwise
   // the other requester. Ready is withheld during reset so nothing is
   // accepted while the state is being cleared.
   always_comb begin
      grant      = req_valid[rr] ? rr : ~rr;
      accept     = (state == S_IDLE) && !reset && req_valid[grant];
      req_ready  = {accept && grant, accept && !grant};
      busy       = (state != S_IDLE);
      resp_valid = (state == S_RESP);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Command execution. Bounds are compared at 32-bit width so that an
   // out-of-range id or index can never alias into a valid slot; the table
   // index aidx is only used once arr_p1 < allocs has been established.
   always_comb begin
      arr_ext   = 32'(arr_p1);
      idx_ext   = 32'(idx_p1);
      aidx      = arr_p1[IW-1:0];
      cur_size  = sizes[aidx];
      cur_ext   = 32'(cur_size);
      base      = arr_ext * 32'(NArea);
      ex_err    = 1'b0;
      ex_data   = '0;
      heap_we   = 1'b0;
      heap_wa   = AW'(base + cur_ext);
      size_we   = 1'b0;
      size_wa   = aidx;
      size_wd   = '0;
      alloc_inc = 1'b0;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      if (op_p1 == OP_ALLOC) begin
         if (top != '0) begin
            stk_pop = 1'b1;
            size_we = 1'b1;
            size_wa = stack[IW'(top - CW'(1))];
            ex_data = W'(stack[IW'(top - CW'(1))]);
         end else if (32'(allocs) < 32'(NArrays)) begin
            alloc_inc = 1'b1;
            size_we   = 1'b1;
            size_wa   = IW'(allocs);
            ex_data   = W'(allocs);
         end else begin
            ex_err = 1'b1;
         end
      end else if (op_p1 == OP_RSVD || arr_ext >= 32'(allocs)) begin
         ex_err = 1'b1;
      end else begin
         case (op_p1)
            OP_FREE: begin
               if (32'(top) >= 32'(NArrays)) ex_err = 1'b1;
               else begin
                  stk_push = 1'b1;
                  size_we  = 1'b1;
               end
            end
            OP_PUSH: begin
               if (cur_ext >= 32'(NArea)) ex_err = 1'b1;
               else begin
                  heap_we = 1'b1;
                  size_we = 1'b1;
                  size_wd = cur_size + W'(1);
                  ex_data = cur_size + W'(1);
               end
            end
            OP_POP: begin
               if (cur_size == '0) ex_err = 1'b1;
               else begin
                  size_we = 1'b1;
                  size_wd = cur_size - W'(1);
                  ex_data = heap[AW'(base + cur_ext - 32'd1)];
               end
            end
            OP_SIZE: ex_data = cur_size;
            OP_READ: begin
               if (idx_ext >= cur_ext) ex_err = 1'b1;
               else ex_data = heap[AW'(base + idx_ext)];
            end
            OP_WRITE: begin
               if (idx_ext >= 32'(NArea)) ex_err = 1'b1;
               else begin
                  heap_we = 1'b1;
                  heap_wa = AW'(base + idx_ext);
                  size_we = 1'b1;
                  size_wd = (idx_ext >= cur_ext) ? idx_p1 + W'(1) : cur_size;
               end
            end
            default: ex_err = 1'b1;
         endcase
      end
   end

   // Control state, size table and response registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         rr         <= 1'b0;
         allocs     <= '0;
         top        <= '0;
         resp_id    <= 1'b0;
         resp_data  <= '0;
         resp_error <= 1'b0;
         for (int i = 0; i < NArrays; i++) sizes[i] <= '0;
      end else begin
         state <= state_nxt;
         // EXEC -> RESP boundary: commit the result and any state change
         if (state == S_EXEC) begin
            resp_id    <= id_p1;
            resp_error <= ex_err;
            resp_data  <= ex_err ? '0 : ex_data;
            if (alloc_inc) allocs <= allocs + CW'(1);
            if (stk_push)  top    <= top + CW'(1);
            if (stk_pop)   top    <= top - CW'(1);
            if (size_we)   sizes[size_wa] <= size_wd;
         end
         if (state == S_RESP) rr <= ~id_p1;
      end
   end

   // IDLE -> EXEC boundary: capture the granted command; heap and stack
   // storage are not cleared by reset but are never written during it.
   always_ff @(posedge clock) begin
      if (accept) begin
         id_p1  <= grant;
         op_p1  <= grant ? req_op[5:3]          : req_op[2:0];
         arr_p1 <= grant ? req_array[2*W-1:W]   : req_array[W-1:0];
         idx_p1 <= grant ? req_index[2*W-1:W]   : req_index[W-1:0];
         dat_p1 <= grant ? req_data[2*W-1:W]    : req_data[W-1:0];
      end
      if (state == S_EXEC && !reset) begin
         if (heap_we)  heap[heap_wa]     <= dat_p1;
         if (stk_push) stack[IW'(top)]   <= aidx;
      end
   end

endmodule
